keycode_arbiter: RTL and testbench

Shares the single USB keyboard keycode stream from the SoC between the two robbers. It decodes per-player direction keys and filters glitches, then queues discrete move requests per player. It auto-repeats held keys on frame boundaries and hands moves to `game` over a valid/ack handshake. It sits between the SoC keycode export and `game`, replacing the raw `Keycode` connection.

---
 rtl/crossy_input_pkg.sv | 59 +++++
 rtl/move_fifo.sv | 77 +++++++
 rtl/keycode_arbiter.sv | 144 ++++++++++++++
 tb/tb_keycode_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/crossy_input_pkg.sv
// Shared types, keycode constants and the per-player key decoder for the keycode arbiter.
package crossy_input_pkg;

  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirDown  = 2'd1,
    DirLeft  = 2'd2,
    DirRight = 2'd3
  } dir_t;

  typedef enum logic {
    Player1 = 1'b0,
    Player2 = 1'b1
  } player_t;

  typedef enum logic {
    StIdle,
    StHeld
  } move_state_e;

  localparam logic [7:0] KeyP1Up    = 8'h1A;
  localparam logic [7:0] KeyP1Down  = 8'h16;
  localparam logic [7:0] KeyP1Left  = 8'h04;
  localparam logic [7:0] KeyP1Right = 8'h07;
  localparam logic [7:0] KeyP2Up    = 8'h52;
  localparam logic [7:0] KeyP2Down  = 8'h51;
  localparam logic [7:0] KeyP2Left  = 8'h50;
  localparam logic [7:0] KeyP2Right = 8'h4F;

  typedef struct packed {
    logic hit;
    dir_t dir;
  } key_map_t;

  function automatic key_map_t map_key(input player_t player, input logic [7:0] code);
    key_map_t m;
    m.hit = 1'b1;
    m.dir = DirUp;
    if (player == Player1) begin
      case (code)
        KeyP1Up:    m.dir = DirUp;
        KeyP1Down:  m.dir = DirDown;
        KeyP1Left:  m.dir = DirLeft;
        KeyP1Right: m.dir = DirRight;
        default:    m.hit = 1'b0;
      endcase
    end else begin
      case (code)
        KeyP2Up:    m.dir = DirUp;
        KeyP2Down:  m.dir = DirDown;
        KeyP2Left:  m.dir = DirLeft;
        KeyP2Right: m.dir = DirRight;
        default:    m.hit = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Per-player move queue with registered head/valid, synchronous flush and full-with-pop push.
module move_fifo
  import crossy_input_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic push_i,
  input  dir_t data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output dir_t data_o
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  dir_t            mem_q [QUEUE_DEPTH];
  dir_t            mem_d [QUEUE_DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            valid_q, valid_d;
  dir_t            head_q, head_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(QUEUE_DEPTH));
  assign empty_o = ~valid_q;
  assign data_o  = head_q;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    do_pop  = pop_i & (count_q != '0);
    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    do_push = push_i & (~full_o | do_pop);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = data_i;
        wptr_d        = wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
    valid_d = (count_d != '0);
    head_d  = mem_d[rptr_d];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '{default: DirUp};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      head_q  <= DirUp;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      head_q  <= head_d;
    end
  end

endmodule

// File: rtl/keycode_arbiter.sv
// Splits the shared keycode stream into debounced, auto-repeating per-player move queues.
module keycode_arbiter
  import crossy_input_pkg::*;
#(
  parameter int unsigned REPEAT_FRAMES = 8,
  parameter int unsigned QUEUE_DEPTH   = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Keycode,
  input  logic       FrameClk,
  input  logic       Enable,
  output logic       P1Valid,
  output logic       P2Valid,
  output logic [1:0] P1Dir,
  output logic [1:0] P2Dir,
  input  logic       P1Ack,
  input  logic       P2Ack,
  output logic [1:0] Overflow
);

  localparam logic [7:0] RepeatCnt = 8'(REPEAT_FRAMES);

  logic [7:0] key_q, acc_q, acc_d;
  logic       key_chg;
  logic       fs1_q, fs2_q, fs3_q;
  logic       tick;
  logic [1:0] ack, valid;
  dir_t       head [2];

  // Accept a code only once two consecutive samples agree.
  always_comb begin
    acc_d = acc_q;
    if (Keycode == key_q) begin
      acc_d = key_q;
    end
  end

  assign key_chg = (acc_d != acc_q);
  assign tick    = fs2_q & ~fs3_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_q <= 8'h00;
      acc_q <= 8'h00;
      fs1_q <= 1'b1;
      fs2_q <= 1'b1;
      fs3_q <= 1'b1;
    end else begin
      key_q <= Keycode;
      acc_q <= acc_d;
      fs1_q <= FrameClk;
      fs2_q <= fs1_q;
      fs3_q <= fs2_q;
    end
  end

  assign ack     = {P2Ack, P1Ack};
  assign P1Valid = valid[0];
  assign P2Valid = valid[1];
  assign P1Dir   = head[0];
  assign P2Dir   = head[1];

  for (genvar gp = 0; gp < 2; gp++) begin : g_player
    localparam player_t Player = (gp == 0) ? Player1 : Player2;

    key_map_t    map;
    move_state_e st_q, st_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        push_q, push_d;
    dir_t        push_dir_q, push_dir_d;
    logic        ovf_q, ovf_d;
    logic        fifo_full, fifo_empty, pop;
    dir_t        fifo_head;

    assign map = map_key(Player, acc_d);

    // push_dir_q always holds the held key's direction while in StHeld.
    always_comb begin
      st_d       = st_q;
      cnt_d      = cnt_q;
      push_d     = 1'b0;
      push_dir_d = push_dir_q;
      if (!Enable) begin
        st_d  = StIdle;
        cnt_d = 8'd0;
      end else if (key_chg) begin
        cnt_d = 8'd0;
        if (map.hit) begin
          st_d       = StHeld;
          push_d     = 1'b1;
          push_dir_d = map.dir;
        end else begin
          st_d = StIdle;
        end
      end else if ((st_q == StHeld) && tick) begin
        if (cnt_q + 8'd1 == RepeatCnt) begin
          cnt_d  = 8'd0;
          push_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end

    assign pop   = ack[gp] & ~fifo_empty;
    assign ovf_d = Enable & push_q & fifo_full & ~pop;

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        st_q       <= StIdle;
        cnt_q      <= 8'd0;
        push_q     <= 1'b0;
        push_dir_q <= DirUp;
        ovf_q      <= 1'b0;
      end else begin
        st_q       <= st_d;
        cnt_q      <= cnt_d;
        push_q     <= push_d;
        push_dir_q <= push_dir_d;
        ovf_q      <= ovf_d;
      end
    end

    move_fifo #(
      .QUEUE_DEPTH(QUEUE_DEPTH)
    ) u_fifo (
      .clk_i  (Clk),
      .rst_ni (Reset_n),
      .flush_i(~Enable),
      .push_i (push_q),
      .data_i (push_dir_q),
      .pop_i  (ack[gp]),
      .full_o (fifo_full),
      .empty_o(fifo_empty),
      .data_o (fifo_head)
    );

    assign valid[gp]    = ~fifo_empty;
    assign head[gp]     = fifo_head;
    assign Overflow[gp] = ovf_q;
  end

endmodule

// File: tb/tb_keycode_arbiter.sv
// Directed bench for keycode_arbiter with hand-computed expectations.
module tb_keycode_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       frame_clk = 1'b1;
  logic       enable = 1'b1;
  logic       p1_valid, p2_valid;
  logic [1:0] p1_dir, p2_dir;
  logic       p1_ack = 1'b0;
  logic       p2_ack = 1'b0;
  logic [1:0] overflow;

  int total = 0;
  int bad = 0;
  int ovf_cnt [2];
  int moves;
  int rpt_ticks[$];

  always #10 clk = ~clk;

  keycode_arbiter #(
    .REPEAT_FRAMES(8),
    .QUEUE_DEPTH  (2)
  ) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .Keycode (keycode),
    .FrameClk(frame_clk),
    .Enable  (enable),
    .P1Valid (p1_valid),
    .P2Valid (p2_valid),
    .P1Dir   (p1_dir),
    .P2Dir   (p2_dir),
    .P1Ack   (p1_ack),
    .P2Ack   (p2_ack),
    .Overflow(overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (overflow[0]) ovf_cnt[0]++;
    if (overflow[1]) ovf_cnt[1]++;
  endtask

  task automatic hold_key(input logic [7:0] code, input int n);
    keycode = code;
    repeat (n) step();
  endtask

  task automatic ack_p1();
    p1_ack = 1'b1;
    step();
    p1_ack = 1'b0;
  endtask

  task automatic ack_p2();
    p2_ack = 1'b1;
    step();
    p2_ack = 1'b0;
  endtask

  // Low pulse then rising edge; four cycles after the rise any repeat move is visible.
  task automatic frame_tick();
    frame_clk = 1'b0;
    repeat (3) step();
    frame_clk = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    ovf_cnt[0] = 0;
    ovf_cnt[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_p1_valid", 32'(p1_valid), 0);
    check_eq("rst_p2_valid", 32'(p2_valid), 0);
    check_eq("rst_p1_dir", 32'(p1_dir), 0);
    check_eq("rst_p2_dir", 32'(p2_dir), 0);
    check_eq("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Single press latency and ack.
    hold_key(8'h1A, 2);
    check_eq("lat_t2_p1_valid", 32'(p1_valid), 0);
    step();
    check_eq("lat_t3_p1_valid", 32'(p1_valid), 1);
    check_eq("lat_t3_p1_dir", 32'(p1_dir), 0);
    check_eq("lat_t3_p2_valid", 32'(p2_valid), 0);
    keycode = 8'h00;
    ack_p1();
    check_eq("ack_p1_valid", 32'(p1_valid), 0);
    hold_key(8'h00, 4);

    // One-cycle glitch must not enqueue.
    hold_key(8'h4F, 1);
    hold_key(8'h00, 6);
    check_eq("glitch_p1_valid", 32'(p1_valid), 0);
    check_eq("glitch_p2_valid", 32'(p2_valid), 0);

    // Held P2 left across 20 frame ticks.
    moves = 0;
    hold_key(8'h50, 4);
    check_eq("rpt_press_valid", 32'(p2_valid), 1);
    check_eq("rpt_press_dir", 32'(p2_dir), 2);
    if (p2_valid) begin
      moves++;
      ack_p2();
    end
    for (int i = 1; i <= 20; i++) begin
      frame_tick();
      if (p2_valid) begin
        moves++;
        rpt_ticks.push_back(i);
        check_eq("rpt_dir", 32'(p2_dir), 2);
        ack_p2();
      end
    end
    check_eq("rpt_moves", 32'(moves), 3);
    check_eq("rpt_n_repeats", 32'(rpt_ticks.size()), 2);
    if (rpt_ticks.size() == 2) begin
      check_eq("rpt_first_tick", 32'(rpt_ticks[0]), 8);
      check_eq("rpt_second_tick", 32'(rpt_ticks[1]), 16);
    end
    check_eq("rpt_p1_valid", 32'(p1_valid), 0);
    hold_key(8'h00, 4);
    check_eq("rpt_release_p2_valid", 32'(p2_valid), 0);

    // Overflow on third press into a two-entry queue.
    ovf_cnt[0] = 0;
    ovf_cnt[1] = 0;
    hold_key(8'h07, 3);
    hold_key(8'h04, 3);
    hold_key(8'h16, 3);
    hold_key(8'h00, 4);
    check_eq("ovf_p1_pulses", 32'(ovf_cnt[0]), 1);
    check_eq("ovf_p2_pulses", 32'(ovf_cnt[1]), 0);
    check_eq("ovf_head_valid", 32'(p1_valid), 1);
    check_eq("ovf_head_dir", 32'(p1_dir), 3);
    ack_p1();
    check_eq("ovf_second_valid", 32'(p1_valid), 1);
    check_eq("ovf_second_dir", 32'(p1_dir), 2);
    ack_p1();
    check_eq("ovf_drained", 32'(p1_valid), 0);

    // Push into a full queue in the same cycle as an ack.
    ovf_cnt[0] = 0;
    hold_key(8'h07, 3);
    hold_key(8'h04, 3);
    check_eq("full_head_dir", 32'(p1_dir), 3);
    hold_key(8'h1A, 2);
    p1_ack = 1'b1;
    step();
    p1_ack = 1'b0;
    hold_key(8'h1A, 1);
    hold_key(8'h00, 4);
    check_eq("full_ack_no_ovf", 32'(ovf_cnt[0]), 0);
    check_eq("full_ack_valid", 32'(p1_valid), 1);
    check_eq("full_ack_head", 32'(p1_dir), 2);
    ack_p1();
    check_eq("full_ack_tail_valid", 32'(p1_valid), 1);
    check_eq("full_ack_tail_dir", 32'(p1_dir), 0);
    ack_p1();
    check_eq("full_ack_drained", 32'(p1_valid), 0);

    // Enable low flushes; held key is not re-enqueued until re-pressed.
    hold_key(8'h52, 3);
    hold_key(8'h1A, 4);
    check_eq("en_p2_queued", 32'(p2_valid), 1);
    check_eq("en_p1_queued", 32'(p1_valid), 1);
    enable = 1'b0;
    step();
    enable = 1'b1;
    check_eq("en_flush_p1", 32'(p1_valid), 0);
    check_eq("en_flush_p2", 32'(p2_valid), 0);
    for (int i = 0; i < 9; i++) frame_tick();
    check_eq("en_held_no_move", 32'(p1_valid), 0);
    hold_key(8'h00, 4);
    hold_key(8'h1A, 4);
    check_eq("en_repress_valid", 32'(p1_valid), 1);
    check_eq("en_repress_dir", 32'(p1_dir), 0);

    // Asynchronous reset between clock edges.
    #4;
    rst_n = 1'b0;
    #2;
    check_eq("async_rst_p1_valid", 32'(p1_valid), 0);
    check_eq("async_rst_overflow", 32'(overflow), 0);
    keycode = 8'h00;
    step();
    check_eq("async_rst_hold_valid", 32'(p1_valid), 0);
    rst_n = 1'b1;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
